// File: rtl/r4_butterfly_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : r4_butterfly_pipe_if
//  Description : Handshake and data bundle for the pipelined radix-4
//                butterfly. The master side drives the input samples, the
//                mode bits and out_ready. The slave side (the butterfly)
//                drives in_ready, the results, out_valid and busy.
//  Ports       : in_valid/in_ready   input handshake
//                inv_i, scale_i      per-transaction mode (forward/inverse, /4)
//                xr0..xr3, xi0..xi3  input samples, W bits signed
//                out_valid/out_ready output handshake
//                Xr0..Xr3, Xi0..Xi3  results, OW = W+2 bits signed
//                busy                any pipeline stage holds valid data
//  Revision    : 1.0  initial release
// ============================================================================
interface r4_butterfly_pipe_if #(
   parameter int W = 8
);
   localparam int OW = W + 2;

   logic                 in_valid;
   logic                 in_ready;
   logic                 inv_i;
   logic                 scale_i;
   logic signed [W-1:0]  xr0, xr1, xr2, xr3;
   logic signed [W-1:0]  xi0, xi1, xi2, xi3;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [OW-1:0] Xr0, Xr1, Xr2, Xr3;
   logic signed [OW-1:0] Xi0, Xi1, Xi2, Xi3;
   logic                 busy;

   modport master (
      output in_valid, inv_i, scale_i,
      output xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3,
      output out_ready,
      input  in_ready, out_valid, busy,
      input  Xr0, Xr1, Xr2, Xr3, Xi0, Xi1, Xi2, Xi3
   );

   modport slave (
      input  in_valid, inv_i, scale_i,
      input  xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3,
      input  out_ready,
      output in_ready, out_valid, busy,
      output Xr0, Xr1, Xr2, Xr3, Xi0, Xi1, Xi2, Xi3
   );
endinterface
`default_nettype wire

// File: rtl/r4_butterfly_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : r4_butterfly_pipe
//  Description : Two-stage pipelined radix-4 complex butterfly with a
//                valid/ready handshake. Stage 1 forms the radix-2 partial
//                sums/differences, stage 2 combines them with the +/-j
//                twiddle chosen per transaction and optionally divides by 4
//                (arithmetic shift, floor). Full precision, no overflow.
//                The whole pipeline stalls together when the output is
//                held and not taken downstream.
//  Ports       : wb_clk_i  clock, rising edge
//                wb_rst_i  asynchronous active-high reset
//                bus       r4_butterfly_pipe_if.slave (handshakes, samples,
//                          mode bits, results, busy)
//  Revision    : 1.0  initial release
// ============================================================================
module r4_butterfly_pipe #(
   parameter int W = 8
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   r4_butterfly_pipe_if.slave bus
);
   localparam int OW = W + 2;
   localparam int NS = 4;

   // ---------------------------------------------------------------- control
   logic v1_q, v2_q;
   logic en;
   logic accept;

   // A single enable for every stage: the pipeline only moves when the
   // output register is empty or being drained this cycle.
   assign en            = !v2_q || bus.out_ready;
   assign accept        = bus.in_valid && en;
   assign bus.in_ready  = en;
   assign bus.out_valid = v2_q;
   assign bus.busy      = v1_q || v2_q;

   // ---------------------------------------------------------------- stage 1
   logic signed [W:0]  xr_e [NS];
   logic signed [W:0]  xi_e [NS];
   logic signed [W:0]  s_r_d [NS];
   logic signed [W:0]  s_i_d [NS];
   logic signed [W:0]  s_r_q [NS];
   logic signed [W:0]  s_i_q [NS];
   logic               inv1_q;
   logic               scale1_q;

   assign xr_e[0] = {bus.xr0[W-1], bus.xr0};
   assign xr_e[1] = {bus.xr1[W-1], bus.xr1};
   assign xr_e[2] = {bus.xr2[W-1], bus.xr2};
   assign xr_e[3] = {bus.xr3[W-1], bus.xr3};
   assign xi_e[0] = {bus.xi0[W-1], bus.xi0};
   assign xi_e[1] = {bus.xi1[W-1], bus.xi1};
   assign xi_e[2] = {bus.xi2[W-1], bus.xi2};
   assign xi_e[3] = {bus.xi3[W-1], bus.xi3};

   always_comb begin
      s_r_d[0] = xr_e[0] + xr_e[2];
      s_r_d[1] = xr_e[0] - xr_e[2];
      s_r_d[2] = xr_e[1] + xr_e[3];
      s_r_d[3] = xr_e[1] - xr_e[3];
      s_i_d[0] = xi_e[0] + xi_e[2];
      s_i_d[1] = xi_e[0] - xi_e[2];
      s_i_d[2] = xi_e[1] + xi_e[3];
      s_i_d[3] = xi_e[1] - xi_e[3];
   end

   // ---------------------------------------------------------------- stage 2
   logic signed [OW-1:0] a_r [NS];
   logic signed [OW-1:0] a_i [NS];
   logic signed [OW-1:0] sum_r [NS];
   logic signed [OW-1:0] sum_i [NS];
   logic signed [OW-1:0] x_r_d [NS];
   logic signed [OW-1:0] x_i_d [NS];
   logic signed [OW-1:0] x_r_q [NS];
   logic signed [OW-1:0] x_i_q [NS];

   // Widen the stage-1 terms to the output width before the second add.
   for (genvar k = 0; k < NS; k++) begin : g_s_ext
      assign a_r[k] = {s_r_q[k][W], s_r_q[k]};
      assign a_i[k] = {s_i_q[k][W], s_i_q[k]};
   end

   always_comb begin
      sum_r[0] = a_r[0] + a_r[2];
      sum_i[0] = a_i[0] + a_i[2];
      sum_r[2] = a_r[0] - a_r[2];
      sum_i[2] = a_i[0] - a_i[2];
      if (!inv1_q) begin
         // X1 = s1 - j*s3, X3 = s1 + j*s3
         sum_r[1] = a_r[1] + a_i[3];
         sum_i[1] = a_i[1] - a_r[3];
         sum_r[3] = a_r[1] - a_i[3];
         sum_i[3] = a_i[1] + a_r[3];
      end else begin
         // X1 = s1 + j*s3, X3 = s1 - j*s3
         sum_r[1] = a_r[1] - a_i[3];
         sum_i[1] = a_i[1] + a_r[3];
         sum_r[3] = a_r[1] + a_i[3];
         sum_i[3] = a_i[1] - a_r[3];
      end
      for (int k = 0; k < NS; k++) begin
         x_r_d[k] = scale1_q ? (sum_r[k] >>> 2) : sum_r[k];
         x_i_d[k] = scale1_q ? (sum_i[k] >>> 2) : sum_i[k];
      end
   end

   // --------------------------------------------------------------- registers
   // Data registers load whenever the pipeline moves, valid or not; the
   // valid bits alone decide whether their contents mean anything.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         inv1_q   <= 1'b0;
         scale1_q <= 1'b0;
         for (int k = 0; k < NS; k++) begin
            s_r_q[k] <= '0;
            s_i_q[k] <= '0;
            x_r_q[k] <= '0;
            x_i_q[k] <= '0;
         end
      end else if (en) begin
         v1_q     <= accept;
         v2_q     <= v1_q;
         inv1_q   <= bus.inv_i;
         scale1_q <= bus.scale_i;
         for (int k = 0; k < NS; k++) begin
            s_r_q[k] <= s_r_d[k];
            s_i_q[k] <= s_i_d[k];
            x_r_q[k] <= x_r_d[k];
            x_i_q[k] <= x_i_d[k];
         end
      end
   end

   assign bus.Xr0 = x_r_q[0];
   assign bus.Xr1 = x_r_q[1];
   assign bus.Xr2 = x_r_q[2];
   assign bus.Xr3 = x_r_q[3];
   assign bus.Xi0 = x_i_q[0];
   assign bus.Xi1 = x_i_q[1];
   assign bus.Xi2 = x_i_q[2];
   assign bus.Xi3 = x_i_q[3];

endmodule
`default_nettype wire

// File: doc/r4_butterfly_pipe.md
Name: r4_butterfly_pipe

Overview:
- Pipelined, parametrised radix-4 complex butterfly with valid/ready handshake, per-transaction forward/inverse mode and optional /4 scaling.
- Successor to the combinational 4-bit butterfly. It sits behind the logic-analyser/Wishbone glue in user_project_wrapper and feeds a future FFT stage controller.
- Accepts four complex samples per transaction and emits four complex results 2 cycles later.

Parameters:
- W, 8, input component width (signed two's complement, per real/imag part); legal range 4..16.
- OW, W+2, output component width; derived, must not be overridden.

Ports:
- wb_clk_i  in  1  clock, all state on rising edge
- wb_rst_i  in  1  asynchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept input this cycle
- inv_i  in  1  0 = forward (-j twiddle), 1 = inverse (+j)
- scale_i  in  1  1 = arithmetic shift right by 2 on all outputs
- xr0..xr3  in  W each  real parts of samples 0..3, signed
- xi0..xi3  in  W each  imaginary parts of samples 0..3, signed
- out_valid  out  1  output transaction valid
- out_ready  in  1  downstream accepts output
- Xr0..Xr3  out  OW each  real parts of results, signed
- Xi0..Xi3  out  OW each  imaginary parts of results, signed
- busy  out  1  any pipeline stage holds valid data

Behaviour:
- Reset (async assert, sync-safe deassert):
  - v1, v2, out_valid = 0; all data registers, Xr*/Xi* = 0; busy = 0.
  - in_ready = 1 after reset.
- Pipeline enable: en = !v2 || out_ready; in_ready = en (combinational).
  - All stages advance together when en = 1 and hold when en = 0 (global stall, no bubbles collapse).
- Accept occurs when in_valid && in_ready.
  - v1 <= accept when en; v2 <= v1 when en.
  - out_valid = v2.
- Stage 1 registers, each W+1 bits, sign-extended before add; inv_i and scale_i captured alongside:
  - s0 = x0 + x2
  - s1 = x0 - x2
  - s2 = x1 + x3
  - s3 = x1 - x3
- Stage 2 registers, OW bits:
  - X0 = s0 + s2
  - X2 = s0 - s2
  - Forward: X1 = s1 - j*s3, i.e. Xr1 = s1r + s3i, Xi1 = s1i - s3r. X3 = s1 + j*s3, i.e. Xr3 = s1r - s3i, Xi3 = s1i + s3r.
  - Inverse: X1 and X3 formulas are swapped.
  - scale: when the captured scale = 1, each stage-2 result is arithmetic-shifted right by 2 (floor, sign-extended to OW) before registering.
- Arithmetic: full-precision, no overflow possible. OW = W+2 covers the worst case 4*(-2^(W-1)) = -2^(W+1).
- Latency: exactly 2 cycles from accept to out_valid when out_ready stays high. Throughput is 1 transaction/cycle.
- Output hold: while out_valid && !out_ready, Xr*/Xi* and out_valid stay stable and in_ready = 0.
- Simultaneous accept and output drain in the same cycle is legal and loses nothing.
- Mode isolation: inv_i and scale_i are sampled only on accept. Changing them mid-flight does not affect in-flight transactions.
- busy = v1 || v2.
- Reset mid-operation: all in-flight transactions are discarded, and outputs go to 0 immediately (asynchronously).
- Data registers may be updated while invalid, but outputs are only meaningful when out_valid = 1.

Test Plan:
- Impulse, forward: W=8, x0=(1,0), others 0, inv=0, scale=0 -> 2 cycles later all X = (1,0), out_valid one cycle, busy drops after.
- x1 impulse, forward and inverse: x1=(1,0), others 0. With inv=0 -> X0=(1,0), X1=(0,-1), X2=(-1,0), X3=(0,1). With inv=1 -> X1=(0,1), X3=(0,-1).
- Extremes and scale:
  - All xr=-128, xi=127, scale=0 -> X0=(-512,508), X1..X3=(0,0).
  - Same inputs, scale=1 -> X0=(-128,127).
  - xr0=-3, rest 0, scale=1 -> all Xr=-1 (floor).
- Back-to-back with backpressure: stream 4 transactions with in_valid held high; hold out_ready=0 for 3 cycles after the first out_valid.
  - Required: in_ready=0 during the stall and outputs stable.
  - Results arrive in order with no loss or duplication; 4 out_valid handshakes total.
- Mode change in flight: accept transaction A with inv=0, then B with inv=1 on consecutive cycles, toggling inv_i after each -> A uses -j and B uses +j, independent of the current inv_i.
- Async reset mid-stream: assert wb_rst_i between clock edges with v1=v2=1 -> out_valid, busy and all X go to 0 immediately. in_ready=1 after release; the next accepted transaction emerges correctly after 2 cycles.
